// File: rtl/systolic_pe_gen_if.sv
// Bus bundle for the generalised spiking systolic PE: weight load/forward,
// A-matrix beat and pass-through, psum in/out, and overflow status.
// The PE itself connects through the slave modport; whatever drives it uses master.
interface systolic_pe_gen_if #(
    parameter int TIME_STEPS  = 4,
    parameter int DATA_W      = 2,
    parameter int WEIGHT_W    = 8,
    parameter int LANE_PSUM_W = 20
);
    // weight bank load and column forwarding
    logic                              weight_valid;
    logic                              weight_load_sel;
    logic                              weight_calc_sel;
    logic [WEIGHT_W-1:0]               weights;
    logic                              out_weight_valid;
    logic [WEIGHT_W-1:0]               out_weights;
    logic                              out_load_sel;

    // A-matrix beat and its row pass-through
    logic                              in_data_valid;
    logic [TIME_STEPS*DATA_W-1:0]      in_raw_data;
    logic                              mode;
    logic                              acc_clear;
    logic                              acc_drain;
    logic                              out_data_valid;
    logic [TIME_STEPS*DATA_W-1:0]      out_raw_data;

    // partial sums
    logic [TIME_STEPS*LANE_PSUM_W-1:0] in_psum_data;
    logic                              out_psum_valid;
    logic [TIME_STEPS*LANE_PSUM_W-1:0] out_psum_data;

    // overflow status
    logic                              ovf_clr;
    logic                              ovf_flag;

    modport slave (
        input  weight_valid, weight_load_sel, weight_calc_sel, weights,
        input  in_data_valid, in_raw_data, mode, acc_clear, acc_drain,
        input  in_psum_data, ovf_clr,
        output out_weight_valid, out_weights, out_load_sel,
        output out_data_valid, out_raw_data,
        output out_psum_valid, out_psum_data, ovf_flag
    );

    modport master (
        output weight_valid, weight_load_sel, weight_calc_sel, weights,
        output in_data_valid, in_raw_data, mode, acc_clear, acc_drain,
        output in_psum_data, ovf_clr,
        input  out_weight_valid, out_weights, out_load_sel,
        input  out_data_valid, out_raw_data,
        input  out_psum_valid, out_psum_data, ovf_flag
    );
endinterface

// File: rtl/systolic_pe_gen.sv
// Generalised spiking systolic PE. Each of TIME_STEPS lanes multiplies a small
// unsigned spike count by one signed weight taken from a ping-pong bank pair.
// Stage 1 registers the exact products; stage 2 either adds them to the
// incoming psum (weight-stationary) or into a local accumulator
// (output-stationary, emitted on drain). Lane sums saturate or wrap, and any
// lane overflow sets a sticky flag.
module systolic_pe_gen #(
    parameter int TIME_STEPS  = 4,
    parameter int DATA_W      = 2,
    parameter int WEIGHT_W    = 8,
    parameter int LANE_PSUM_W = 20,
    parameter int SATURATE    = 1
) (
    input  logic             s_clk,
    input  logic             s_rst,
    systolic_pe_gen_if.slave bus
);
    // Product of an unsigned DATA_W count (made signed with one extra bit)
    // and a signed weight is exact in this width.
    localparam int PROD_W = WEIGHT_W + DATA_W + 1;
    // One guard bit above the psum width exposes overflow of the addition.
    localparam int EXT_W  = LANE_PSUM_W + 1;

    localparam logic signed [LANE_PSUM_W-1:0] PSUM_MAX = {1'b0, {(LANE_PSUM_W-1){1'b1}}};
    localparam logic signed [LANE_PSUM_W-1:0] PSUM_MIN = {1'b1, {(LANE_PSUM_W-1){1'b0}}};

    logic signed [WEIGHT_W-1:0]        bank0_reg;
    logic signed [WEIGHT_W-1:0]        bank1_reg;
    logic signed [WEIGHT_W-1:0]        w_calc;

    logic                              out_weight_valid_reg;
    logic [WEIGHT_W-1:0]               out_weights_reg;
    logic                              out_load_sel_reg;
    logic                              out_data_valid_reg;
    logic [TIME_STEPS*DATA_W-1:0]      out_raw_data_reg;

    logic                              v1_reg;
    logic                              mode_s_reg;
    logic                              clear_s_reg;
    logic                              ws_beat;
    logic                              os_beat;

    logic                              out_psum_valid_reg;
    logic                              out_psum_valid_next;
    logic                              ovf_flag_reg;
    logic                              ovf_flag_next;
    logic [TIME_STEPS-1:0]             lane_ovf;
    logic [TIME_STEPS*LANE_PSUM_W-1:0] psum_out_flat;

    // Banks are registers, so a write to the calc bank only becomes visible
    // to the multiplier on the following cycle.
    assign w_calc = bus.weight_calc_sel ? bank1_reg : bank0_reg;

    assign ws_beat = v1_reg & ~mode_s_reg;
    assign os_beat = v1_reg &  mode_s_reg;

    // A drain outputs even when it collides with a weight-stationary beat;
    // in that case the lane registers take the weight-stationary result.
    assign out_psum_valid_next = ws_beat | bus.acc_drain;

    // Set beats clear when both happen in the same cycle.
    assign ovf_flag_next = (|lane_ovf) | (ovf_flag_reg & ~bus.ovf_clr);

    // Weight banks and the unconditional column-forward registers.
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            bank0_reg            <= '0;
            bank1_reg            <= '0;
            out_weight_valid_reg <= 1'b0;
            out_weights_reg      <= '0;
            out_load_sel_reg     <= 1'b0;
        end else begin
            if (bus.weight_valid && !bus.weight_load_sel) begin
                bank0_reg <= bus.weights;
            end
            if (bus.weight_valid && bus.weight_load_sel) begin
                bank1_reg <= bus.weights;
            end
            out_weight_valid_reg <= bus.weight_valid;
            out_weights_reg      <= bus.weights;
            out_load_sel_reg     <= bus.weight_load_sel;
        end
    end

    // Stage-1 control capture, row pass-through, output valid and overflow flag.
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            v1_reg             <= 1'b0;
            mode_s_reg         <= 1'b0;
            clear_s_reg        <= 1'b0;
            out_data_valid_reg <= 1'b0;
            out_raw_data_reg   <= '0;
            out_psum_valid_reg <= 1'b0;
            ovf_flag_reg       <= 1'b0;
        end else begin
            v1_reg <= bus.in_data_valid;
            if (bus.in_data_valid) begin
                mode_s_reg  <= bus.mode;
                clear_s_reg <= bus.acc_clear;
            end
            out_data_valid_reg <= bus.in_data_valid;
            out_raw_data_reg   <= bus.in_raw_data;
            out_psum_valid_reg <= out_psum_valid_next;
            ovf_flag_reg       <= ovf_flag_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < TIME_STEPS; gi++) begin : g_lane
            logic [DATA_W-1:0]             data_lane;
            logic signed [PROD_W-1:0]      data_ext;
            logic signed [PROD_W-1:0]      weight_ext;
            logic signed [PROD_W-1:0]      prod_next;
            logic signed [PROD_W-1:0]      prod_reg;
            logic signed [LANE_PSUM_W-1:0] psum_in;
            logic signed [LANE_PSUM_W-1:0] acc_reg;
            logic signed [LANE_PSUM_W-1:0] base;
            logic signed [LANE_PSUM_W-1:0] res;
            logic signed [LANE_PSUM_W-1:0] out_reg;
            logic signed [EXT_W-1:0]       sum_ext;
            logic                          ovf;

            assign data_lane  = bus.in_raw_data[gi*DATA_W +: DATA_W];
            assign data_ext   = {{(PROD_W-DATA_W){1'b0}}, data_lane};
            assign weight_ext = {{(PROD_W-WEIGHT_W){w_calc[WEIGHT_W-1]}}, w_calc};
            assign prod_next  = data_ext * weight_ext;

            assign psum_in = bus.in_psum_data[gi*LANE_PSUM_W +: LANE_PSUM_W];
            // Addend: psum-in for weight-stationary, accumulator (or zero on
            // the first beat of a run) for output-stationary.
            assign base    = mode_s_reg ? (clear_s_reg ? '0 : acc_reg) : psum_in;
            assign sum_ext = {base[LANE_PSUM_W-1], base}
                           + {{(EXT_W-PROD_W){prod_reg[PROD_W-1]}}, prod_reg};
            assign ovf     = sum_ext[LANE_PSUM_W] ^ sum_ext[LANE_PSUM_W-1];

            // Clamp toward the sign of the true sum, or keep the low bits.
            always_comb begin
                res = sum_ext[LANE_PSUM_W-1:0];
                if (SATURATE != 0 && ovf) begin
                    res = sum_ext[LANE_PSUM_W] ? PSUM_MIN : PSUM_MAX;
                end
            end

            assign lane_ovf[gi] = v1_reg & ovf;

            // Per-lane product, accumulator and psum output registers.
            always_ff @(posedge s_clk) begin
                if (s_rst) begin
                    prod_reg <= '0;
                    acc_reg  <= '0;
                    out_reg  <= '0;
                end else begin
                    if (bus.in_data_valid) begin
                        prod_reg <= prod_next;
                    end
                    if (bus.acc_drain) begin
                        acc_reg <= '0;
                    end else if (os_beat) begin
                        acc_reg <= res;
                    end
                    if (ws_beat) begin
                        out_reg <= res;
                    end else if (bus.acc_drain) begin
                        out_reg <= os_beat ? res : acc_reg;
                    end
                end
            end

            assign psum_out_flat[gi*LANE_PSUM_W +: LANE_PSUM_W] = out_reg;
        end
    endgenerate

    assign bus.out_weight_valid = out_weight_valid_reg;
    assign bus.out_weights      = out_weights_reg;
    assign bus.out_load_sel     = out_load_sel_reg;
    assign bus.out_data_valid   = out_data_valid_reg;
    assign bus.out_raw_data     = out_raw_data_reg;
    assign bus.out_psum_valid   = out_psum_valid_reg;
    assign bus.out_psum_data    = psum_out_flat;
    assign bus.ovf_flag         = ovf_flag_reg;

    // Draining while a weight-stationary beat completes loses the accumulator.
    drain_vs_ws_beat : assert property (@(posedge s_clk) disable iff (s_rst)
        !(bus.acc_drain && ws_beat));

endmodule

// File: tb/tb_systolic_pe_gen.sv
// Bench for systolic_pe_gen: a saturating and a wrapping instance share the
// same stimulus; expected psum vectors are queued per instance and popped by
// one monitor per instance whenever out_psum_valid is seen.
module tb_systolic_pe_gen;
    localparam int TS = 4;
    localparam int DW = 2;
    localparam int WW = 8;
    localparam int PW = 20;
    localparam int VW = TS * PW;

    logic s_clk = 1'b0;
    logic s_rst;
    always #5 s_clk = ~s_clk;

    systolic_pe_gen_if #(.TIME_STEPS(TS), .DATA_W(DW), .WEIGHT_W(WW), .LANE_PSUM_W(PW)) bus_s ();
    systolic_pe_gen_if #(.TIME_STEPS(TS), .DATA_W(DW), .WEIGHT_W(WW), .LANE_PSUM_W(PW)) bus_w ();

    assign bus_w.weight_valid    = bus_s.weight_valid;
    assign bus_w.weight_load_sel = bus_s.weight_load_sel;
    assign bus_w.weight_calc_sel = bus_s.weight_calc_sel;
    assign bus_w.weights         = bus_s.weights;
    assign bus_w.in_data_valid   = bus_s.in_data_valid;
    assign bus_w.in_raw_data     = bus_s.in_raw_data;
    assign bus_w.mode            = bus_s.mode;
    assign bus_w.acc_clear       = bus_s.acc_clear;
    assign bus_w.acc_drain       = bus_s.acc_drain;
    assign bus_w.in_psum_data    = bus_s.in_psum_data;
    assign bus_w.ovf_clr         = bus_s.ovf_clr;

    systolic_pe_gen #(.TIME_STEPS(TS), .DATA_W(DW), .WEIGHT_W(WW), .LANE_PSUM_W(PW), .SATURATE(1))
        u_sat (.s_clk(s_clk), .s_rst(s_rst), .bus(bus_s.slave));
    systolic_pe_gen #(.TIME_STEPS(TS), .DATA_W(DW), .WEIGHT_W(WW), .LANE_PSUM_W(PW), .SATURATE(0))
        u_wrap (.s_clk(s_clk), .s_rst(s_rst), .bus(bus_w.slave));

    typedef struct {
        int            id;
        logic [VW-1:0] sat;
        logic [VW-1:0] wrp;
    } exp_t;

    exp_t q_s[$];
    exp_t q_w[$];
    exp_t e_s;
    exp_t e_w;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_push   = 0;

    task automatic chk(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h required=%h @%0t", nm, got, exp, $time);
        end else begin
            $display("ok   %s value=%h @%0t", nm, got, $time);
        end
    endtask

    function automatic logic [VW-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
        return {a3[PW-1:0], a2[PW-1:0], a1[PW-1:0], a0[PW-1:0]};
    endfunction

    task automatic push(input logic [VW-1:0] s, input logic [VW-1:0] w);
        exp_t e;
        e.id  = n_push;
        e.sat = s;
        e.wrp = w;
        n_push++;
        q_s.push_back(e);
        q_w.push_back(e);
    endtask

    task automatic tick();
        @(posedge s_clk);
        #1;
    endtask

    task automatic set_data(input int d0, input int d1, input int d2, input int d3);
        bus_s.in_raw_data = {d3[DW-1:0], d2[DW-1:0], d1[DW-1:0], d0[DW-1:0]};
    endtask

    task automatic set_psum(input int p0, input int p1, input int p2, input int p3);
        bus_s.in_psum_data = pack4(p0, p1, p2, p3);
    endtask

    task automatic load_w(input logic sel, input int w);
        bus_s.weight_valid    = 1'b1;
        bus_s.weight_load_sel = sel;
        bus_s.weights         = w[WW-1:0];
        tick();
        bus_s.weight_valid    = 1'b0;
    endtask

    task automatic beat(input logic m, input logic clr);
        bus_s.in_data_valid = 1'b1;
        bus_s.mode          = m;
        bus_s.acc_clear     = clr;
        tick();
        bus_s.in_data_valid = 1'b0;
        bus_s.acc_clear     = 1'b0;
    endtask

    task automatic drain();
        bus_s.acc_drain = 1'b1;
        tick();
        bus_s.acc_drain = 1'b0;
    endtask

    task automatic chk_ovf(input string nm, input logic v);
        chk({nm, "_sat"},  VW'(bus_s.ovf_flag), VW'(v));
        chk({nm, "_wrap"}, VW'(bus_w.ovf_flag), VW'(v));
    endtask

    // Saturating-instance monitor.
    always @(negedge s_clk) begin
        if (bus_s.out_psum_valid === 1'b1) begin
            if (q_s.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sat_unexpected_valid got=%h required=no output @%0t",
                         bus_s.out_psum_data, $time);
            end else begin
                e_s = q_s.pop_front();
                chk($sformatf("sat_psum#%0d", e_s.id), bus_s.out_psum_data, e_s.sat);
            end
        end
    end

    // Wrapping-instance monitor.
    always @(negedge s_clk) begin
        if (bus_w.out_psum_valid === 1'b1) begin
            if (q_w.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wrap_unexpected_valid got=%h required=no output @%0t",
                         bus_w.out_psum_data, $time);
            end else begin
                e_w = q_w.pop_front();
                chk($sformatf("wrap_psum#%0d", e_w.id), bus_w.out_psum_data, e_w.wrp);
            end
        end
    end

    initial begin
        s_rst                 = 1'b1;
        bus_s.weight_valid    = 1'b0;
        bus_s.weight_load_sel = 1'b0;
        bus_s.weight_calc_sel = 1'b0;
        bus_s.weights         = '0;
        bus_s.in_data_valid   = 1'b0;
        bus_s.in_raw_data     = '0;
        bus_s.mode            = 1'b0;
        bus_s.acc_clear       = 1'b0;
        bus_s.acc_drain       = 1'b0;
        bus_s.in_psum_data    = '0;
        bus_s.ovf_clr         = 1'b0;
        repeat (3) tick();

        // reset state
        chk("rst_psum_valid", VW'(bus_s.out_psum_valid), '0);
        chk("rst_psum_data",  bus_s.out_psum_data, '0);
        chk("rst_out_wvalid", VW'(bus_s.out_weight_valid), '0);
        chk("rst_out_dvalid", VW'(bus_s.out_data_valid), '0);
        chk_ovf("rst_ovf", 1'b0);
        s_rst = 1'b0;
        tick();

        // 1: weight-stationary, two-cycle latency, one-cycle valid
        load_w(1'b0, -5);
        bus_s.weight_calc_sel = 1'b0;
        set_psum(100, 100, 100, 100);
        set_data(0, 1, 2, 3);
        push(pack4(100, 95, 90, 85), pack4(100, 95, 90, 85));
        beat(1'b0, 1'b0);
        chk("t1_valid_after_1clk", VW'(bus_s.out_psum_valid), '0);
        tick();
        chk("t1_valid_after_2clk", VW'(bus_s.out_psum_valid), VW'(1));
        tick();
        chk("t1_valid_one_cycle", VW'(bus_s.out_psum_valid), '0);
        chk_ovf("t1_ovf", 1'b0);

        // 2: ping-pong banks under a continuous beat stream
        set_data(1, 1, 1, 1);
        bus_s.weight_valid    = 1'b1;
        bus_s.weight_load_sel = 1'b1;
        bus_s.weights         = 8'd7;
        push(pack4(95, 95, 95, 95), pack4(95, 95, 95, 95));
        beat(1'b0, 1'b0);
        chk("t2_fwd_wvalid",  VW'(bus_s.out_weight_valid), VW'(1));
        chk("t2_fwd_weights", VW'(bus_s.out_weights), VW'(7));
        chk("t2_fwd_loadsel", VW'(bus_s.out_load_sel), VW'(1));
        chk("t2_pass_dvalid", VW'(bus_s.out_data_valid), VW'(1));
        chk("t2_pass_raw",    VW'(bus_s.out_raw_data), VW'(8'h55));
        bus_s.weight_valid = 1'b0;
        push(pack4(95, 95, 95, 95), pack4(95, 95, 95, 95));
        beat(1'b0, 1'b0);
        chk("t2_fwd_wvalid_drop", VW'(bus_s.out_weight_valid), '0);
        bus_s.weight_calc_sel = 1'b1;
        push(pack4(107, 107, 107, 107), pack4(107, 107, 107, 107));
        beat(1'b0, 1'b0);
        push(pack4(107, 107, 107, 107), pack4(107, 107, 107, 107));
        beat(1'b0, 1'b0);
        // write and calc on bank1 in the same cycle: old value 7 still used
        bus_s.weight_valid    = 1'b1;
        bus_s.weight_load_sel = 1'b1;
        bus_s.weights         = 8'd20;
        push(pack4(107, 107, 107, 107), pack4(107, 107, 107, 107));
        beat(1'b0, 1'b0);
        bus_s.weight_valid = 1'b0;
        push(pack4(120, 120, 120, 120), pack4(120, 120, 120, 120));
        beat(1'b0, 1'b0);
        repeat (3) tick();

        // 3: positive overflow, sticky flag, clear, set-beats-clear
        load_w(1'b0, 127);
        bus_s.weight_calc_sel = 1'b0;
        set_psum(524287, 0, 0, 0);
        set_data(1, 0, 0, 0);
        push(pack4(524287, 0, 0, 0), pack4(-524162, 0, 0, 0));
        beat(1'b0, 1'b0);
        tick();
        chk_ovf("t3_ovf_set", 1'b1);
        repeat (3) tick();
        chk_ovf("t3_ovf_sticky", 1'b1);
        bus_s.ovf_clr = 1'b1;
        tick();
        bus_s.ovf_clr = 1'b0;
        chk_ovf("t3_ovf_cleared", 1'b0);
        // negative overflow while ovf_clr is held
        load_w(1'b1, -128);
        bus_s.weight_calc_sel = 1'b1;
        set_psum(0, -524288, 0, 0);
        set_data(0, 1, 0, 0);
        bus_s.ovf_clr = 1'b1;
        push(pack4(0, -524288, 0, 0), pack4(0, 524160, 0, 0));
        beat(1'b0, 1'b0);
        tick();
        chk_ovf("t3_set_wins", 1'b1);
        bus_s.ovf_clr = 1'b0;
        tick();
        chk_ovf("t3_set_held", 1'b1);
        bus_s.ovf_clr = 1'b1;
        tick();
        bus_s.ovf_clr = 1'b0;

        // 4: output-stationary accumulate and drain
        load_w(1'b0, 10);
        bus_s.weight_calc_sel = 1'b0;
        set_data(3, 0, 0, 0);
        set_psum(555, 555, 555, 555);
        beat(1'b1, 1'b1);
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b0);
        repeat (3) tick();
        push(pack4(90, 0, 0, 0), pack4(90, 0, 0, 0));
        drain();
        chk("t4_drain_valid", VW'(bus_s.out_psum_valid), VW'(1));
        tick();
        chk("t4_drain_one_cycle", VW'(bus_s.out_psum_valid), '0);
        beat(1'b1, 1'b0);
        repeat (2) tick();
        push(pack4(30, 0, 0, 0), pack4(30, 0, 0, 0));
        drain();
        repeat (2) tick();

        // 5: drain on the same edge as the last stage-2 beat
        beat(1'b1, 1'b1);
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b0);
        push(pack4(90, 0, 0, 0), pack4(90, 0, 0, 0));
        drain();
        repeat (2) tick();
        push(pack4(0, 0, 0, 0), pack4(0, 0, 0, 0));
        drain();
        repeat (2) tick();
        // mode changes beat to beat
        set_psum(100, 100, 100, 100);
        push(pack4(130, 100, 100, 100), pack4(130, 100, 100, 100));
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b1);
        repeat (2) tick();
        push(pack4(30, 0, 0, 0), pack4(30, 0, 0, 0));
        drain();
        repeat (2) tick();

        // 6: reset with beats in flight
        load_w(1'b0, 127);
        bus_s.weight_calc_sel = 1'b0;
        set_psum(524287, 0, 0, 0);
        set_data(1, 0, 0, 0);
        push(pack4(524287, 0, 0, 0), pack4(-524162, 0, 0, 0));
        beat(1'b0, 1'b0);
        repeat (2) tick();
        chk_ovf("t6_ovf_before_rst", 1'b1);
        bus_s.in_data_valid = 1'b1;
        tick();
        s_rst = 1'b1;
        tick();
        bus_s.in_data_valid = 1'b0;
        tick();
        chk("t6_rst_psum_valid", VW'(bus_s.out_psum_valid), '0);
        chk("t6_rst_out_weights", VW'(bus_s.out_weights), '0);
        chk("t6_rst_dvalid", VW'(bus_s.out_data_valid), '0);
        chk_ovf("t6_rst_ovf", 1'b0);
        s_rst = 1'b0;
        repeat (2) tick();
        set_psum(42, 42, 42, 42);
        set_data(3, 0, 0, 0);
        bus_s.weight_calc_sel = 1'b0;
        push(pack4(42, 42, 42, 42), pack4(42, 42, 42, 42));
        beat(1'b0, 1'b0);
        bus_s.weight_calc_sel = 1'b1;
        push(pack4(42, 42, 42, 42), pack4(42, 42, 42, 42));
        beat(1'b0, 1'b0);
        repeat (5) tick();
        chk_ovf("t6_post_ovf", 1'b0);

        chk("sb_sat_all_seen",  VW'(q_s.size()), '0);
        chk("sb_wrap_all_seen", VW'(q_w.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_pe_gen.md
Name: systolic_pe_gen

Overview:
Parametrised successor of the spiking systolic PE. It multiplies a TIME_STEPS-lane vector of small unsigned spike counts by one signed weight, without using DSPs. The weight comes from a ping-pong bank pair, and weights can be forwarded down the column. The block runs in one of two modes, selected per beat:
- Mode 0, weight-stationary: the block adds its product to the incoming psum and passes the result on.
- Mode 1, output-stationary: the block keeps a local accumulator and emits it only on drain.
Every lane has saturating (or wrapping) arithmetic and a sticky overflow flag. The block sits in the Transformer systolic array as the drop-in generalised PE.

Parameters:
TIME_STEPS, 4, number of independent time-step lanes
DATA_W, 2, unsigned spike-count width per lane
WEIGHT_W, 8, signed weight width
LANE_PSUM_W, 20, signed psum width per lane
SATURATE, 1, 1 = clamp on overflow; 0 = two's-complement wrap

Ports:
s_clk  in  1  clock
s_rst  in  1  synchronous active-high reset
weight_valid  in  1  write weights into bank weight_load_sel
weight_load_sel  in  1  bank written (0/1)
weight_calc_sel  in  1  bank used by multiplier
weights  in  WEIGHT_W  signed weight
out_weight_valid  out  1  weight_valid delayed 1 clk (column forward)
out_weights  out  WEIGHT_W  weights delayed 1 clk
out_load_sel  out  1  weight_load_sel delayed 1 clk
in_data_valid  in  1  A-matrix beat valid
in_raw_data  in  TIME_STEPS*DATA_W  lane t at [t*DATA_W +: DATA_W]
mode  in  1  0 = weight-stationary, 1 = output-stationary; sampled with in_data_valid
acc_clear  in  1  mode 1: beat starts from zero accumulator; sampled with in_data_valid
acc_drain  in  1  mode 1: emit accumulator
out_data_valid  out  1  in_data_valid delayed 1 clk
out_raw_data  out  TIME_STEPS*DATA_W  in_raw_data delayed 1 clk
in_psum_data  in  TIME_STEPS*LANE_PSUM_W  mode 0 psum-in, aligned to stage 2 (1 clk after beat)
out_psum_valid  out  1  psum result valid
out_psum_data  out  TIME_STEPS*LANE_PSUM_W  psum result, lane t at [t*LANE_PSUM_W +: LANE_PSUM_W]
ovf_clr  in  1  clear ovf_flag
ovf_flag  out  1  sticky overflow indicator

Behaviour:
- Reset (s_rst=1 at an edge) zeroes the following, and any in-flight beat is discarded:
  - all outputs;
  - both weight banks;
  - the product registers;
  - the accumulators;
  - the stage valids;
  - the sampled mode.
- Weight banks:
  - On weight_valid, bank[weight_load_sel] <= weights.
  - Forward registers always load: out_weight_valid/out_weights/out_load_sel <= inputs.
  - Write and calc on the same bank in the same cycle: the multiplier uses the pre-write value.
- Stage 1 (edge after in_data_valid=1):
  - Per lane, prod_t <= data_t * bank[weight_calc_sel], signed, WEIGHT_W+DATA_W+1 bits, exact (no truncation).
  - mode and acc_clear are captured at the same edge.
  - prod holds when no beat is present.
  - out_data_valid/out_raw_data are always registered, as a pass-through to the right neighbour.
- Stage 2 (edge after stage-1 valid):
  - Sign-extend the sum to LANE_PSUM_W+1 bits.
  - Mode 0:
    - out_psum_data lane <= sat(in_psum lane + prod);
    - out_psum_valid = stage-1 valid delayed 1, so total latency is 2 clk.
  - Mode 1:
    - acc lane <= sat((acc_clear_s ? 0 : acc) + prod);
    - out_psum_valid does not pulse on the beat.
- Drain (mode 1):
  - acc_drain=1 at an edge gives out_psum_data <= the accumulator's next value, including a product completing that same edge, and out_psum_valid=1 for 1 clk.
  - acc <= 0 at that same edge.
  - Drain coincident with a mode-0 stage-2 beat: the mode-0 result wins and the accumulator is cleared without output. This is a documented usage error, flagged by an assertion.
- out_psum_data holds when out_psum_valid=0.
- Overflow:
  - Detected when bit LANE_PSUM_W differs from bit LANE_PSUM_W-1 of the extended sum.
  - SATURATE=1: clamp to +2^(LANE_PSUM_W-1)-1 or -2^(LANE_PSUM_W-1). SATURATE=0: keep the low bits.
  - Any lane overflowing sets ovf_flag at the next edge.
  - ovf_clr clears ovf_flag; set and clear in the same cycle: set wins.
- Back-to-back beats every cycle are supported with no bubbles.
- mode may change beat-to-beat; each beat completes in its own sampled mode.

Test Plan:
1. Bank0=-5, mode 0, in_raw_data lanes(3..0)={3,2,1,0}, in_psum all lanes 100 → 2 clk later out_psum lanes(3..0)={85,90,95,100}, out_psum_valid 1 clk, ovf_flag=0.
2. Ping-pong: calc bank0=-5; load bank1=7 during a continuous beat stream; flip weight_calc_sel → beats before the flip use -5 and after use 7 (lane data 1 → 107), with no glitch; out_weights delayed exactly 1 clk.
3. Saturation: in_psum lane0=524287, bank=127, data lane0=1 → lane0=524287, ovf_flag=1 sticky; repeat with SATURATE=0 → lane0=-524162; ovf_clr together with a new overflow → flag stays 1.
4. Mode 1: weight 10, lane0 data 3, three beats with acc_clear on the first → no psum_valid; acc_drain → out lane0=90, valid 1 clk; next beat without clear → accumulation starts from 0 (drain again gives 30).
5. Drain on the same edge as the last stage-2 beat → output includes that product (90, not 60); accumulator is then 0.
6. Assert s_rst mid-stream with beats in flight → no out_psum_valid after reset; banks=0; ovf_flag=0; a post-reset beat with data 3 gives 0 + psum-in.
